// File: rtl/coin_front_end.sv
// coin_front_end
// Upstream conditioning stage for the soda vending FSM. The three raw coin
// sensor lines are synchronized, debounced and classified by one shared FSM.
// Clean single-cycle strobes come out for accepted coins, and a reject strobe
// goes to the return gate. A wrapping counter of accepted coins is kept for
// diagnostics.
//
// Ports
//   clk       rising-edge system clock
//   rst       asynchronous, active-low reset
//   n_raw     raw nickel sensor (asynchronous, may bounce)
//   d_raw     raw dime sensor (asynchronous, may bounce)
//   q_raw     raw quarter sensor (asynchronous, may bounce)
//   lock      vending FSM busy; a coin that qualifies while this is high is refused
//   N, D, Q   one-cycle strobes: nickel / dime / quarter accepted
//   coin_rej  one-cycle strobe: coin refused (several lines at once, or locked)
//   acc_cnt   accepted-coin count, wraps to zero after all-ones
module coin_front_end #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 8,
    parameter int ACC_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_raw,
    input  logic             d_raw,
    input  logic             q_raw,
    input  logic             lock,
    output logic             N,
    output logic             D,
    output logic             Q,
    output logic             coin_rej,
    output logic [ACC_W-1:0] acc_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [2:0]       meta;
    logic [2:0]       s;
    logic [2:0]       cap;
    logic [DEB_W-1:0] cnt;
    state_t           state;
    logic             one_hot;

    // Two-flop synchronizer; s = {nickel, dime, quarter} and nothing
    // downstream ever looks at the raw lines directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 3'b000;
            s    <= 3'b000;
        end else begin
            meta <= {n_raw, d_raw, q_raw};
            s    <= meta;
        end
    end

    assign one_hot = (cap == 3'b100) || (cap == 3'b010) || (cap == 3'b001);

    // Shared debounce/classify FSM. Starting in RELEASE means a line that is
    // already high when reset lifts must first go quiet before any coin can
    // be recognised. The decision is taken on the edge where the captured
    // pattern has been stable for DEB_CYCLES evaluations, and lock is only
    // looked at on that edge. cnt is cleared on the decision so the release
    // phase always needs a full DEB_CYCLES of quiet lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RELEASE;
            cap      <= 3'b000;
            cnt      <= '0;
            N        <= 1'b0;
            D        <= 1'b0;
            Q        <= 1'b0;
            coin_rej <= 1'b0;
            acc_cnt  <= '0;
        end else begin
            N        <= 1'b0;
            D        <= 1'b0;
            Q        <= 1'b0;
            coin_rej <= 1'b0;
            case (state)
                IDLE: begin
                    if (s != 3'b000) begin
                        cap   <= s;
                        cnt   <= '0;
                        state <= QUAL;
                    end
                end
                QUAL: begin
                    if (s == 3'b000) begin
                        state <= IDLE;
                    end else if (s != cap) begin
                        cap <= s;
                        cnt <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + DEB_W'(1);
                    end else begin
                        if (one_hot && !lock) begin
                            N       <= cap[2];
                            D       <= cap[1];
                            Q       <= cap[0];
                            acc_cnt <= acc_cnt + ACC_W'(1);
                        end else begin
                            coin_rej <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (s != 3'b000) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= RELEASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_front_end.sv
// tb_coin_front_end
// Self-checking bench for coin_front_end (DEB_CYCLES=4). Inputs are driven on
// the falling edge. Each coin inserted is turned into an expected strobe
// (which output, and on which clock edge) from the coin's final stable
// pattern and the lock level. A monitor records every strobe the design
// produces, and the two lists are compared at the end. acc_cnt is checked
// after every coin against a running count of accepted coins.
//
// Ports: none (top-level bench).
module tb_coin_front_end;

    logic       clk;
    logic       rst;
    logic       n_raw;
    logic       d_raw;
    logic       q_raw;
    logic       lock;
    logic       N;
    logic       D;
    logic       Q;
    logic       coin_rej;
    logic [7:0] acc_cnt;

    typedef struct {
        logic [3:0] vec;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc;
    int  tests_run;
    int  tests_failed;
    int  acc_model;

    coin_front_end #(
        .DEB_CYCLES(4),
        .DEB_W(8),
        .ACC_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .n_raw(n_raw),
        .d_raw(d_raw),
        .q_raw(q_raw),
        .lock(lock),
        .N(N),
        .D(D),
        .Q(Q),
        .coin_rej(coin_rej),
        .acc_cnt(acc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe as {N,D,Q,coin_rej} with the edge count; two
    // strobes in one cycle or a two-cycle pulse both show up as mismatches.
    always @(negedge clk) begin
        if (rst && (N || D || Q || coin_rej)) begin
            ev_t e;
            e.vec = {N, D, Q, coin_rej};
            e.cyc = cyc;
            obs_q.push_back(e);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic setLines(input logic [2:0] p);
        n_raw = p[2];
        d_raw = p[1];
        q_raw = p[0];
    endtask

    // One coin: optional one-cycle glitches, optional short wrong pattern,
    // the real pattern held for 'hold' cycles, optional bounce on the falling
    // side, then 'gap' quiet cycles. A coin is accepted only if exactly one
    // line was high and lock was low; the strobe appears 7 edges after the
    // final pattern first reaches the pins.
    task automatic applyStimulus(input logic [2:0] pat, input int hold, input logic lk,
                                 input int n_glitch, input logic [2:0] pre_pat,
                                 input int pre_len, input logic tail_bounce, input int gap);
        ev_t e;
        lock = lk;
        for (int i = 0; i < n_glitch; i++) begin
            setLines(3'($urandom_range(1, 7)));
            @(negedge clk);
            setLines(3'b000);
            @(negedge clk);
        end
        if (pre_len > 0) begin
            setLines(pre_pat);
            repeat (pre_len) @(negedge clk);
        end
        setLines(pat);
        e.cyc = cyc + 7;
        if ($countones(pat) == 1 && !lk) begin
            e.vec = {pat, 1'b0};
            acc_model = (acc_model + 1) % 256;
        end else begin
            e.vec = 4'b0001;
        end
        exp_q.push_back(e);
        repeat (hold) @(negedge clk);
        if (tail_bounce) begin
            setLines(3'b000);
            @(negedge clk);
            setLines(pat);
            @(negedge clk);
        end
        setLines(3'b000);
        for (int i = 0; i < gap; i++) begin
            if (i >= 2) lock = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput("acc_cnt", int'(acc_cnt), acc_model);
    endtask

    initial begin
        logic [2:0] pat;
        logic [2:0] pre_pat;
        int n;

        cyc = 0;
        tests_run = 0;
        tests_failed = 0;
        acc_model = 0;
        rst = 1'b0;
        lock = 1'b0;
        setLines(3'b100);

        // Nickel line held high through reset and its release.
        repeat (3) @(negedge clk);
        checkOutput("rst_N", int'(N), 0);
        checkOutput("rst_D", int'(D), 0);
        checkOutput("rst_Q", int'(Q), 0);
        checkOutput("rst_rej", int'(coin_rej), 0);
        checkOutput("rst_acc", int'(acc_cnt), 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("held_no_strobe", obs_q.size(), 0);
        setLines(3'b000);
        repeat (6) @(negedge clk);
        applyStimulus(3'b100, 10, 1'b0, 0, 3'b000, 0, 1'b0, 8);

        // Clean nickel, glitchy nickel, dime+quarter, locked quarter, quarter.
        applyStimulus(3'b100, 12, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        applyStimulus(3'b100, 10, 1'b0, 2, 3'b000, 0, 1'b0, 8);
        applyStimulus(3'b011, 10, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        applyStimulus(3'b001, 10, 1'b1, 0, 3'b000, 0, 1'b0, 8);
        applyStimulus(3'b001, 10, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        // Dime arriving while a quarter is qualifying, then nickel bouncing on release.
        applyStimulus(3'b011, 8, 1'b0, 0, 3'b001, 2, 1'b0, 8);
        applyStimulus(3'b100, 8, 1'b0, 0, 3'b000, 0, 1'b1, 8);

        // Randomized coins.
        for (int k = 0; k < 40; k++) begin
            pat = 3'($urandom_range(1, 7));
            do pre_pat = 3'($urandom_range(1, 7)); while (pre_pat == pat);
            n = $urandom_range(0, 3);
            applyStimulus(pat, $urandom_range(6, 10), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 2), pre_pat, n,
                          1'($urandom_range(0, 1)), $urandom_range(8, 12));
        end

        // Nickel, two dimes, then 256 nickels at 8 high / 8 low; acc_cnt wraps.
        applyStimulus(3'b100, 8, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        applyStimulus(3'b010, 8, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        applyStimulus(3'b010, 8, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        for (int k = 0; k < 256; k++) begin
            applyStimulus(3'b100, 8, 1'b0, 0, 3'b000, 0, 1'b0, 8);
        end

        // Reset in the middle of qualifying a coin: the strobe is lost.
        lock = 1'b0;
        setLines(3'b010);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        acc_model = 0;
        @(negedge clk);
        checkOutput("midrst_acc", int'(acc_cnt), 0);
        checkOutput("midrst_D", int'(D), 0);
        setLines(3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        applyStimulus(3'b010, 8, 1'b0, 0, 3'b000, 0, 1'b0, 8);

        repeat (5) @(negedge clk);
        checkOutput("event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput($sformatf("ev%0d_kind", i), int'(obs_q[i].vec), int'(exp_q[i].vec));
            checkOutput($sformatf("ev%0d_cycle", i), obs_q[i].cyc, exp_q[i].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
